// File: rtl/accum_buffer.sv
// Per-lane accumulate buffer fed by the crossbar: two-stage read-modify-write with same-address
// forwarding, then an end-of-tile drain that streams out and clears every entry.
module accum_buffer #(
  parameter int unsigned NUM_DST = 4,
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned ACC_W   = 32,
  parameter int unsigned X_DEPTH = 8,
  parameter int unsigned K_DEPTH = 4
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic [NUM_DST-1:0]                   in_valid,
  input  logic [NUM_DST*DATA_W-1:0]            in_data,
  input  logic [NUM_DST*$clog2(X_DEPTH)-1:0]   in_x,
  input  logic [NUM_DST*$clog2(K_DEPTH)-1:0]   in_k,
  input  logic                                 xbar_empty,
  input  logic                                 tile_done,
  input  logic                                 out_ready,
  output logic                                 out_valid,
  output logic [ACC_W-1:0]                     out_data,
  output logic [$clog2(X_DEPTH)-1:0]           out_x,
  output logic [$clog2(NUM_DST)-1:0]           out_y,
  output logic [$clog2(K_DEPTH)-1:0]           out_k,
  output logic                                 busy,
  output logic                                 drain_done,
  output logic                                 drop_err
);

  localparam int unsigned XW    = $clog2(X_DEPTH);
  localparam int unsigned KW    = $clog2(K_DEPTH);
  localparam int unsigned YW    = $clog2(NUM_DST);
  localparam int unsigned Depth = X_DEPTH * K_DEPTH;
  localparam int unsigned AW    = $clog2(Depth);

  typedef enum logic [1:0] {StAccum, StFlush, StDrain} state_e;

  state_e               state_q;
  logic                 flush_seen_q;
  logic                 drop_err_q;
  logic                 drain_done_q;
  logic [ACC_W-1:0]     mem_q     [NUM_DST][Depth];
  logic [NUM_DST-1:0]   s1_valid_q;
  logic [AW-1:0]        s1_addr_q [NUM_DST];
  logic [ACC_W-1:0]     s1_data_q [NUM_DST];
  logic [ACC_W-1:0]     s1_rd_q   [NUM_DST];
  logic [XW-1:0]        cnt_x_q;
  logic [KW-1:0]        cnt_k_q;
  logic [YW-1:0]        cnt_y_q;

  logic [AW-1:0]        in_addr [NUM_DST];
  logic [ACC_W-1:0]     in_ext  [NUM_DST];
  logic [ACC_W-1:0]     rd_fwd  [NUM_DST];
  logic [ACC_W-1:0]     s2_sum  [NUM_DST];
  logic [AW-1:0]        drain_addr;
  logic                 accept;
  logic                 last_entry;
  logic                 flush_empty;

  always_comb begin
    for (int i = 0; i < NUM_DST; i++) begin
      in_addr[i] = AW'(in_k[i*KW +: KW]) * AW'(X_DEPTH) + AW'(in_x[i*XW +: XW]);
      in_ext[i]  = {{(ACC_W-DATA_W){in_data[i*DATA_W+DATA_W-1]}}, in_data[i*DATA_W +: DATA_W]};
      s2_sum[i]  = s1_rd_q[i] + s1_data_q[i];
      // The S2 write lands at the end of this cycle, so a same-address read must take the sum.
      rd_fwd[i]  = (s1_valid_q[i] && (s1_addr_q[i] == in_addr[i])) ? s2_sum[i]
                                                                    : mem_q[i][in_addr[i]];
    end
  end

  assign accept      = (state_q != StDrain);
  assign drain_addr  = AW'(cnt_k_q) * AW'(X_DEPTH) + AW'(cnt_x_q);
  assign last_entry  = (cnt_x_q == XW'(X_DEPTH-1)) && (cnt_k_q == KW'(K_DEPTH-1)) &&
                       (cnt_y_q == YW'(NUM_DST-1));
  assign flush_empty = xbar_empty && !(|in_valid) && !(|s1_valid_q);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= StAccum;
      flush_seen_q <= 1'b0;
      drop_err_q   <= 1'b0;
      drain_done_q <= 1'b0;
      s1_valid_q   <= '0;
      cnt_x_q      <= '0;
      cnt_k_q      <= '0;
      cnt_y_q      <= '0;
      for (int i = 0; i < NUM_DST; i++) begin
        s1_addr_q[i] <= '0;
        s1_data_q[i] <= '0;
        s1_rd_q[i]   <= '0;
        for (int j = 0; j < Depth; j++) mem_q[i][j] <= '0;
      end
    end else begin
      drain_done_q <= 1'b0;
      s1_valid_q   <= accept ? in_valid : '0;
      for (int i = 0; i < NUM_DST; i++) begin
        if (accept && in_valid[i]) begin
          s1_addr_q[i] <= in_addr[i];
          s1_data_q[i] <= in_ext[i];
          s1_rd_q[i]   <= rd_fwd[i];
        end
        if (s1_valid_q[i]) mem_q[i][s1_addr_q[i]] <= s2_sum[i];
      end
      if (!accept && (|in_valid)) drop_err_q <= 1'b1;

      unique case (state_q)
        StAccum: begin
          if (tile_done) begin
            state_q      <= StFlush;
            flush_seen_q <= 1'b0;
          end
        end
        StFlush: begin
          // First FLUSH cycle always passes so the pipeline gets a cycle to retire.
          flush_seen_q <= 1'b1;
          if (flush_seen_q && flush_empty) state_q <= StDrain;
        end
        StDrain: begin
          if (out_ready) begin
            mem_q[cnt_y_q][drain_addr] <= '0;
            if (cnt_x_q == XW'(X_DEPTH-1)) begin
              cnt_x_q <= '0;
              if (cnt_k_q == KW'(K_DEPTH-1)) begin
                cnt_k_q <= '0;
                cnt_y_q <= (cnt_y_q == YW'(NUM_DST-1)) ? '0 : cnt_y_q + YW'(1);
              end else begin
                cnt_k_q <= cnt_k_q + KW'(1);
              end
            end else begin
              cnt_x_q <= cnt_x_q + XW'(1);
            end
            if (last_entry) begin
              state_q      <= StAccum;
              drain_done_q <= 1'b1;
            end
          end
        end
        default: state_q <= StAccum;
      endcase
    end
  end

  assign out_valid  = (state_q == StDrain);
  assign out_data   = mem_q[cnt_y_q][drain_addr];
  assign out_x      = cnt_x_q;
  assign out_k      = cnt_k_q;
  assign out_y      = cnt_y_q;
  assign busy       = (state_q != StAccum);
  assign drain_done = drain_done_q;
  assign drop_err   = drop_err_q;

endmodule

// File: tb/tb_accum_buffer.sv
// Bench for accum_buffer: vector table plus reference accumulator model; every drained word is
// checked against a scoreboard queue built from the model.
module tb_accum_buffer;

  localparam int NDst = 4;
  localparam int XD   = 8;
  localparam int KD   = 4;
  localparam int Dep  = XD * KD;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  in_valid = '0;
  logic [63:0] in_data = '0;
  logic [11:0] in_x = '0;
  logic [7:0]  in_k = '0;
  logic        xbar_empty = 1'b1;
  logic        tile_done = 1'b0;
  logic        out_ready = 1'b0;
  logic        out_valid;
  logic [31:0] out_data;
  logic [2:0]  out_x;
  logic [1:0]  out_y;
  logic [1:0]  out_k;
  logic        busy;
  logic        drain_done;
  logic        drop_err;

  accum_buffer #(
    .NUM_DST(4),
    .DATA_W (16),
    .ACC_W  (32),
    .X_DEPTH(8),
    .K_DEPTH(4)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_x      (in_x),
    .in_k      (in_k),
    .xbar_empty(xbar_empty),
    .tile_done (tile_done),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_x     (out_x),
    .out_y     (out_y),
    .out_k     (out_k),
    .busy      (busy),
    .drain_done(drain_done),
    .drop_err  (drop_err)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [3:0] vm;
    int         x;
    int         k;
    int         d;
  } vec_t;

  typedef struct {
    int          y;
    int          k;
    int          x;
    logic [31:0] v;
  } word_t;

  int          total = 0;
  int          bad = 0;
  logic [31:0] model [NDst][Dep];
  word_t       sbq [$];
  word_t       chk [5];
  vec_t        vecs [12];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Drive one cycle of inputs (same x/k/data on every lane in vm) and update the model.
  task automatic drive(input logic [3:0] vm, input int x, input int k, input int d);
    in_valid = vm;
    for (int l = 0; l < NDst; l++) begin
      in_x[l*3 +: 3]     = 3'(x);
      in_k[l*2 +: 2]     = 2'(k);
      in_data[l*16 +: 16] = 16'(d);
      if (vm[l]) model[l][k*XD+x] = model[l][k*XD+x] + 32'(d);
    end
    tick();
    in_valid = '0;
  endtask

  // mode 0: ready held high; mode 1: ready pattern 1,0,0,1 repeating.
  task automatic drain(input int mode, input bit use_chk, input bit inject, input int abort_at,
                       input int exp_flush);
    int    flush_cyc;
    int    cyc;
    int    hs;
    word_t e;
    sbq.delete();
    for (int y = 0; y < NDst; y++)
      for (int k = 0; k < KD; k++)
        for (int x = 0; x < XD; x++) begin
          sbq.push_back('{y, k, x, model[y][k*XD+x]});
          model[y][k*XD+x] = '0;
        end
    tile_done = 1'b1;
    tick();
    tile_done = 1'b0;
    check("busy_flush", 64'(busy), 64'(1));
    flush_cyc = 0;
    while (!out_valid && flush_cyc < 20) begin
      flush_cyc++;
      tick();
    end
    if (!out_valid) begin
      check("drain_start", 64'(out_valid), 64'(1));
      return;
    end
    if (exp_flush > 0) check("flush_cycles", 64'(flush_cyc), 64'(exp_flush));
    cyc = 0;
    hs  = 0;
    while (sbq.size() > 0 && cyc < 1000) begin
      out_ready = (mode == 0) ? 1'b1 : (((cyc % 4) == 1 || (cyc % 4) == 2) ? 1'b0 : 1'b1);
      if (inject && cyc == 3) begin
        in_valid  = 4'hF;
        in_x      = {4{3'd2}};
        in_k      = {4{2'd1}};
        in_data   = {4{16'd1000}};
        tile_done = 1'b1;
      end else begin
        in_valid  = '0;
        tile_done = 1'b0;
      end
      if (inject && cyc == 5) check("drop_err_set", 64'(drop_err), 64'(1));
      e = sbq[0];
      check("out_valid_drain", 64'(out_valid), 64'(1));
      check("drain_done_early", 64'(drain_done), 64'(0));
      check("drain_word", 64'({out_y, out_k, out_x, out_data}),
            64'({2'(e.y), 2'(e.k), 3'(e.x), e.v}));
      if (use_chk)
        foreach (chk[j])
          if (chk[j].y == e.y && chk[j].k == e.k && chk[j].x == e.x)
            check("const_word", 64'(out_data), 64'(chk[j].v));
      if (out_ready) begin
        void'(sbq.pop_front());
        hs++;
      end
      if (abort_at > 0 && hs == abort_at) begin
        out_ready = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_drop_err", 64'(drop_err), 64'(0));
        check("rst_drain_done", 64'(drain_done), 64'(0));
        sbq.delete();
        return;
      end
      cyc++;
      tick();
    end
    out_ready = 1'b0;
    check("drain_left", 64'(sbq.size()), 64'(0));
    if (mode == 0) check("drain_cycles", 64'(cyc), 64'(NDst*Dep));
    check("done_pulse", 64'(drain_done), 64'(1));
    check("done_out_valid", 64'(out_valid), 64'(0));
    check("done_busy", 64'(busy), 64'(0));
    tick();
    check("done_clear", 64'(drain_done), 64'(0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int l = 0; l < NDst; l++)
      for (int a = 0; a < Dep; a++) model[l][a] = '0;

    vecs[0]  = '{4'b0010, 3, 2, 5};
    vecs[1]  = '{4'b0010, 3, 2, -2};
    vecs[2]  = '{4'b0010, 3, 2, 10};
    vecs[3]  = '{4'b1111, 0, 0, 7};
    vecs[4]  = '{4'b1111, 0, 0, 7};
    vecs[5]  = '{4'b1111, 0, 0, 7};
    vecs[6]  = '{4'b0100, 7, 3, -100};
    vecs[7]  = '{4'b1000, 5, 1, 300};
    vecs[8]  = '{4'b0001, 1, 0, -1};
    vecs[9]  = '{4'b0000, 0, 0, 0};
    vecs[10] = '{4'b0001, 1, 0, -1};
    vecs[11] = '{4'b0110, 6, 2, 12345};
    chk[0] = '{1, 2, 3, 32'd13};
    chk[1] = '{0, 0, 0, 32'd21};
    chk[2] = '{1, 0, 0, 32'd21};
    chk[3] = '{2, 0, 0, 32'd21};
    chk[4] = '{3, 0, 0, 32'd21};

    // Reset state.
    tick();
    tick();
    reset = 1'b0;
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_out_word", 64'({out_y, out_k, out_x, out_data}), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_drain_done", 64'(drain_done), 64'(0));
    check("rst_drop_err", 64'(drop_err), 64'(0));

    // Empty tile: exactly two FLUSH cycles, 128 zero words.
    drain(0, 1'b0, 1'b0, 0, 2);

    // Vector table with forwarding hits, drained with a stalling consumer.
    foreach (vecs[i]) drive(vecs[i].vm, vecs[i].x, vecs[i].k, vecs[i].d);
    drain(1, 1'b1, 1'b0, 0, 0);

    // Second tile after a drain starts from zero.
    drain(0, 1'b0, 1'b0, 0, 2);

    // Wrap: -32768 summed 65537 times on every lane.
    for (int i = 0; i < 65537; i++) drive(4'hF, 4, 1, -32768);
    check("wrap_model", 64'(model[2][1*XD+4]), 64'(32'h7FFF_8000));
    drain(0, 1'b0, 1'b0, 0, 0);

    // Inputs during DRAIN are dropped and flagged; stray tile_done ignored.
    drive(4'b0001, 2, 1, 9);
    drain(0, 1'b0, 1'b1, 0, 0);
    check("drop_err_sticky", 64'(drop_err), 64'(1));

    // Reset mid-drain, then the next drain must be all zeros.
    drive(4'b1000, 7, 3, 77);
    drive(4'b0100, 0, 0, 5);
    drain(0, 1'b0, 1'b0, 20, 0);
    for (int l = 0; l < NDst; l++)
      for (int a = 0; a < Dep; a++) model[l][a] = '0;
    drain(0, 1'b0, 1'b0, 0, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
